// File: rtl/twiddle_fetch.sv
// Twiddle sequencer: reads cos(k) and cos(k+3N/4) from the cosine LUT and returns the pair.
// Optional macro TWIDDLE_NEGATE_SIN_EN: out_sin carries the saturated negation of sin.
module twiddle_fetch #(
    parameter int AW      = 10,
    parameter int DW      = 18,
    parameter int LUT_LAT = 1
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_k,
    output logic [AW-1:0] lut_addr,
    input  logic [DW-1:0] lut_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_cos,
    output logic [DW-1:0] out_sin,
    output logic [AW-1:0] out_k,
    output logic          busy
);

    typedef enum logic [2:0] {IDLE, ISSUE_C, ISSUE_S, DRAIN, OUT} state_t;

    localparam logic [AW-1:0] SIN_OFS = AW'((3 << AW) >> 2);

    state_t               state, state_nxt;
    logic [2:0]           cnt;
    logic [LUT_LAT-1:0]   tag_c, tag_s;
    logic [DW-1:0]        sin_val;

    always_ff @(posedge Clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = ISSUE_C;
            end
            ISSUE_C: state_nxt = ISSUE_S;
            ISSUE_S: state_nxt = DRAIN;
            DRAIN:   if (cnt == 3'd0) state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef TWIDDLE_NEGATE_SIN_EN
    // -(-2^(DW-1)) is not representable; clamp to the positive full scale
    always_comb begin
        sin_val = ~lut_dout + DW'(1);
        if (lut_dout == {1'b1, {(DW-1){1'b0}}}) sin_val = {1'b0, {(DW-1){1'b1}}};
    end
`else
    always_comb sin_val = lut_dout;
`endif

    always_ff @(posedge Clk) begin
        if (!reset) begin
            lut_addr <= '0;
            out_k    <= '0;
            out_cos  <= '0;
            out_sin  <= '0;
            cnt      <= '0;
            tag_c    <= '0;
            tag_s    <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                out_k    <= req_k;
                lut_addr <= req_k;
            end
            if (state == ISSUE_C) lut_addr <= out_k + SIN_OFS;
            if (state == ISSUE_S) cnt <= 3'(LUT_LAT - 1);
            if (state == DRAIN)   cnt <= cnt - 3'd1;

            // Tags mark which edge carries the data for each issued address
            tag_c[0] <= (state == ISSUE_C);
            tag_s[0] <= (state == ISSUE_S);
            for (int unsigned i = 1; i < LUT_LAT; i++) begin
                tag_c[i] <= tag_c[i-1];
                tag_s[i] <= tag_s[i-1];
            end

            if (tag_c[LUT_LAT-1]) out_cos <= lut_dout;
            if (tag_s[LUT_LAT-1]) out_sin <= sin_val;
        end
    end

endmodule

// File: tb/tb_twiddle_fetch.sv
// Bench: two twiddle_fetch instances (LUT_LAT=1 and LUT_LAT=3) share stimulus; results are
// checked against a cosine-table reference model.
module tb_twiddle_fetch;

    logic              Clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [9:0]        req_k = '0;

    logic [9:0]        addr_a, addr_b, k_a, k_b;
    logic signed [17:0] dout_a, dout_b, cos_a, cos_b, sin_a, sin_b;
    logic              rdy_a, rdy_b, ov_a, ov_b, busy_a, busy_b;

    logic signed [17:0] lut [0:1023];
    logic signed [17:0] p1_b, p2_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    twiddle_fetch #(.AW(10), .DW(18), .LUT_LAT(1)) dut_a (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_a), .req_k(req_k),
        .lut_addr(addr_a), .lut_dout(dout_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_cos(cos_a), .out_sin(sin_a), .out_k(k_a), .busy(busy_a)
    );

    twiddle_fetch #(.AW(10), .DW(18), .LUT_LAT(3)) dut_b (
        .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy_b), .req_k(req_k),
        .lut_addr(addr_b), .lut_dout(dout_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_cos(cos_b), .out_sin(sin_b), .out_k(k_b), .busy(busy_b)
    );

    // Behavioural LUTs with 1 and 3 clocks of read latency
    always @(posedge Clk) begin
        dout_a <= lut[addr_a];
        p1_b   <= lut[addr_b];
        p2_b   <= p1_b;
        dout_b <= p2_b;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int model_cos(input int k);
        return int'(lut[k % 1024]);
    endfunction

    function automatic int model_sin(input int k);
        int v;
        v = int'(lut[(k + 768) % 1024]);
`ifdef TWIDDLE_NEGATE_SIN_EN
        v = (v == -131072) ? 131071 : -v;
`endif
        return v;
    endfunction

`ifdef TWIDDLE_NEGATE_SIN_EN
    localparam int SGN = -1;
`else
    localparam int SGN = 1;
`endif

    // Starts and ends at a falling edge.
    task automatic run_txn(input int k, input int hold, input bit keep_req, input int k_next);
        int lat_a, lat_b, ec, es;
        req_valid = 1'b1;
        req_k     = 10'(k);
        check("req_ready_a", int'(rdy_a), 1);
        check("req_ready_b", int'(rdy_b), 1);
        @(posedge Clk); @(negedge Clk);
        req_valid = 1'b0;
        check("addr_cos_a", int'(addr_a), k);
        check("addr_cos_b", int'(addr_b), k);
        check("busy_a", int'(busy_a), 1);
        @(posedge Clk); @(negedge Clk);
        check("addr_sin_a", int'(addr_a), (k + 768) % 1024);
        check("addr_sin_b", int'(addr_b), (k + 768) % 1024);
        lat_a = 0;
        lat_b = 0;
        for (int e = 2; e <= 12 && (lat_a == 0 || lat_b == 0); e++) begin
            @(posedge Clk); @(negedge Clk);
            if (ov_a && lat_a == 0) lat_a = e;
            if (ov_b && lat_b == 0) lat_b = e;
        end
        check("latency_a", lat_a, 3);
        check("latency_b", lat_b, 5);
        ec = model_cos(k);
        es = model_sin(k);
        check("cos_a", int'(cos_a), ec);
        check("sin_a", int'(sin_a), es);
        check("k_a", int'(k_a), k);
        check("cos_b", int'(cos_b), ec);
        check("sin_b", int'(sin_b), es);
        check("k_b", int'(k_b), k);
        if (keep_req) begin
            req_valid = 1'b1;
            req_k     = 10'(k_next);
        end
        repeat (hold) begin
            @(posedge Clk); @(negedge Clk);
            check("hold_valid_a", int'(ov_a), 1);
            check("hold_ready_a", int'(rdy_a), 0);
            check("hold_cos_a", int'(cos_a), ec);
            check("hold_k_a", int'(k_a), k);
            check("hold_sin_b", int'(sin_b), es);
        end
        out_ready = 1'b1;
        @(posedge Clk); @(negedge Clk);
        out_ready = 1'b0;
        check("release_valid_a", int'(ov_a), 0);
        check("release_valid_b", int'(ov_b), 0);
        check("release_ready_a", int'(rdy_a), 1);
        check("release_busy_b", int'(busy_b), 0);
        check("kept_sin_a", int'(sin_a), es);
        check("kept_cos_b", int'(cos_b), ec);
    endtask

    initial begin
        int v, seen;
        for (int a = 0; a < 1024; a++) begin
            v = int'(131071.0 * $cos(2.0 * 3.14159265358979 * a / 1024.0));
            lut[a] = 18'(v);
        end

        reset = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_addr_a", int'(addr_a), 0);
        check("rst_cos_a", int'(cos_a), 0);
        check("rst_valid_a", int'(ov_a), 0);
        check("rst_ready_a", int'(rdy_a), 1);
        check("rst_busy_b", int'(busy_b), 0);
        reset = 1'b1;

        run_txn(0, 0, 1'b0, 0);
        check("k0_cos", int'(cos_a), 131071);
        check("k0_sin", int'(sin_a), 0);
        run_txn(256, 1, 1'b0, 0);
        check("k256_cos", int'(cos_a), 0);
        check("k256_sin", int'(sin_a), SGN * 131071);
        run_txn(128, 0, 1'b0, 0);
        check("k128_cos", int'(cos_a), 92681);
        check("k128_sin", int'(sin_a), SGN * 92681);
        run_txn(512, 0, 1'b0, 0);
        check("k512_cos_b", int'(cos_b), -131071);
        check("k512_sin_b", int'(sin_b), 0);
        run_txn(1023, 0, 1'b0, 0);
        run_txn(768, 0, 1'b0, 0);
        check("k768_sin", int'(sin_a), SGN * -131071);

        // Backpressure with a second request held during OUT, accepted after release
        run_txn(64, 10, 1'b1, 300);
        run_txn(300, 0, 1'b0, 0);

        // Reset pulse while in ISSUE_S aborts the request
        req_valid = 1'b1;
        req_k     = 10'd100;
        @(posedge Clk); @(negedge Clk);
        req_valid = 1'b0;
        @(posedge Clk); @(negedge Clk);
        reset = 1'b0;
        @(posedge Clk); @(negedge Clk);
        reset = 1'b1;
        check("abort_addr_a", int'(addr_a), 0);
        check("abort_k_b", int'(k_b), 0);
        check("abort_cos_a", int'(cos_a), 0);
        check("abort_sin_a", int'(sin_a), 0);
        check("abort_ready_b", int'(rdy_b), 1);
        seen = 0;
        repeat (8) begin
            @(posedge Clk); @(negedge Clk);
            if (ov_a || ov_b || busy_a || busy_b) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        run_txn(5, 1, 1'b0, 0);

        // Full-scale negative table entry: raw pass-through or saturated negate
        lut[0] = -18'sd131072;
        run_txn(256, 0, 1'b0, 0);
        check("sat_sin_a", int'(sin_a), (SGN == 1) ? -131072 : 131071);
        lut[0] = 18'sd131071;

        for (int i = 0; i < 20; i++)
            run_txn(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)), 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
